// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes a MIPS instruction, selects the ALU operands and
// registers them into the EX stage behind a valid/ready handshake with
// stall and flush support.
module alu_issue_stage #(
  parameter int unsigned DATA_W     = 32,
  parameter logic [3:0]  ILLEGAL_OP = 4'b0010
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_rs_val,
  input  logic [DATA_W-1:0] in_rt_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  output logic [1:0]        AluzeroCtr,
  output logic              is_branch,
  output logic              illegal
);

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0110,
    ALU_XOR  = 4'b0111,
    ALU_NOR  = 4'b1100,
    ALU_FSUB = 4'b1110
  } alu_op_e;

  logic [5:0]        opcode;
  logic [4:0]        rt_field;
  logic [5:0]        funct;
  logic [15:0]       imm;
  logic [DATA_W-1:0] imm_se;
  logic [DATA_W-1:0] imm_ze;

  logic [DATA_W-1:0] dec_a;
  logic [DATA_W-1:0] dec_b;
  logic [3:0]        dec_op;
  logic [1:0]        dec_zc;
  logic              dec_br;
  logic              dec_ill;

  logic              transfer;
  logic              unused_rs_field;

  assign opcode   = in_instr[31:26];
  assign rt_field = in_instr[20:16];
  assign funct    = in_instr[5:0];
  assign imm      = in_instr[15:0];
  assign imm_se   = {{(DATA_W-16){imm[15]}}, imm};
  assign imm_ze   = {{(DATA_W-16){1'b0}}, imm};

  // Register indices are resolved upstream; only the values are used here.
  assign unused_rs_field = ^in_instr[25:21];

  assign in_ready = !rst && (!out_valid || out_ready);
  assign transfer = in_valid && in_ready && !flush;

  // Instruction decode and operand selection; defaults describe an illegal op.
  always_comb begin
    dec_a   = in_rs_val;
    dec_b   = in_rt_val;
    dec_op  = ILLEGAL_OP;
    dec_zc  = 2'b00;
    dec_br  = 1'b0;
    dec_ill = 1'b1;
    unique case (opcode)
      6'h00: begin
        dec_ill = 1'b0;
        case (funct)
          6'h20, 6'h21: dec_op = ALU_ADD;
          6'h22, 6'h23: dec_op = ALU_SUB;
          6'h24:        dec_op = ALU_AND;
          6'h25:        dec_op = ALU_OR;
          6'h26:        dec_op = ALU_XOR;
          6'h27:        dec_op = ALU_NOR;
          default: begin
            dec_op  = ILLEGAL_OP;
            dec_ill = 1'b1;
          end
        endcase
      end
      6'h08, 6'h09, 6'h23, 6'h2B: begin
        dec_op  = ALU_ADD;
        dec_b   = imm_se;
        dec_ill = 1'b0;
      end
      6'h0C: begin
        dec_op  = ALU_AND;
        dec_b   = imm_ze;
        dec_ill = 1'b0;
      end
      6'h0D: begin
        dec_op  = ALU_OR;
        dec_b   = imm_ze;
        dec_ill = 1'b0;
      end
      6'h0E: begin
        dec_op  = ALU_XOR;
        dec_b   = imm_ze;
        dec_ill = 1'b0;
      end
      6'h04: begin
        dec_op  = ALU_SUB;
        dec_zc  = 2'b00;
        dec_br  = 1'b1;
        dec_ill = 1'b0;
      end
      6'h05: begin
        dec_op  = ALU_SUB;
        dec_zc  = 2'b01;
        dec_br  = 1'b1;
        dec_ill = 1'b0;
      end
      6'h07: begin
        dec_op  = ALU_SUB;
        dec_b   = '0;
        dec_zc  = 2'b10;
        dec_br  = 1'b1;
        dec_ill = 1'b0;
      end
      6'h06: begin
        dec_op  = ALU_FSUB;
        dec_b   = '0;
        dec_zc  = 2'b11;
        dec_br  = 1'b1;
        dec_ill = 1'b0;
      end
      6'h01: begin
        if (rt_field == 5'd1) begin
          dec_op  = ALU_SUB;
          dec_b   = '0;
          dec_zc  = 2'b11;
          dec_br  = 1'b1;
          dec_ill = 1'b0;
        end else if (rt_field == 5'd0) begin
          dec_op  = ALU_FSUB;
          dec_b   = '0;
          dec_zc  = 2'b10;
          dec_br  = 1'b1;
          dec_ill = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // EX-stage register: reset beats flush, flush beats transfer, stall holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      AluzeroCtr <= '0;
      is_branch  <= 1'b0;
      illegal    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (transfer) begin
      out_valid  <= 1'b1;
      alu_a      <= dec_a;
      alu_b      <= dec_b;
      alu_op     <= dec_op;
      AluzeroCtr <= dec_zc;
      is_branch  <= dec_br;
      illegal    <= dec_ill;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed testbench for alu_issue_stage with hand-computed expectations.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs_val;
  logic [31:0] in_rt_val;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [1:0]  AluzeroCtr;
  logic        is_branch;
  logic        illegal;

  int unsigned n_checks;
  int unsigned n_fail;

  alu_issue_stage #(.DATA_W(32), .ILLEGAL_OP(4'b0010)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_rs_val  (in_rs_val),
    .in_rt_val  (in_rt_val),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .AluzeroCtr (AluzeroCtr),
    .is_branch  (is_branch),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] i_instr(input logic [5:0] op, input logic [15:0] imm);
    return {op, 5'd1, 5'd2, imm};
  endfunction

  function automatic logic [31:0] r_instr(input logic [5:0] fn);
    return {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, fn};
  endfunction

  function automatic logic [31:0] regimm(input logic [4:0] rt);
    return {6'h01, 5'd1, rt, 16'h0010};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single edge, then drop in_valid.
  task automatic send(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt);
    in_instr  = instr;
    in_rs_val = rs;
    in_rt_val = rt;
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
  endtask

  task automatic expect_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [1:0] zc, input logic br,
                           input logic ill);
    check({tag, "_vld"}, 32'(out_valid), 32'd1);
    check({tag, "_op"},  32'(alu_op), 32'(op));
    check({tag, "_a"},   alu_a, a);
    check({tag, "_b"},   alu_b, b);
    check({tag, "_zc"},  32'(AluzeroCtr), 32'(zc));
    check({tag, "_br"},  32'(is_branch), 32'(br));
    check({tag, "_ill"}, 32'(illegal), 32'(ill));
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_rs_val = '0;
    in_rt_val = '0;
    out_ready = 1'b1;
    step();
    step();

    // Reset state
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_vld",   32'(out_valid), 32'd0);
    check("rst_a",     alu_a, 32'd0);
    check("rst_b",     alu_b, 32'd0);
    check("rst_op",    32'(alu_op), 32'd0);
    check("rst_zc",    32'(AluzeroCtr), 32'd0);
    check("rst_br",    32'(is_branch), 32'd0);
    check("rst_ill",   32'(illegal), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(in_ready), 32'd1);

    // addi with negative immediate: sign extension
    send(i_instr(6'h08, 16'hFFFF), 32'd5, 32'd7);
    expect_op("addi", 4'b0010, 32'd5, 32'hFFFF_FFFF, 2'b00, 1'b0, 1'b0);
    step();
    check("addi_drain", 32'(out_valid), 32'd0);

    // ori zero-extends; back-to-back with nor
    send(i_instr(6'h0D, 16'h8001), 32'h10, 32'h99);
    expect_op("ori", 4'b0001, 32'h10, 32'h0000_8001, 2'b00, 1'b0, 1'b0);
    send(r_instr(6'h27), 32'h10, 32'h22);
    expect_op("nor", 4'b1100, 32'h10, 32'h22, 2'b00, 1'b0, 1'b0);
    send(i_instr(6'h0C, 16'h8001), 32'h33, 32'h99);
    expect_op("andi", 4'b0000, 32'h33, 32'h0000_8001, 2'b00, 1'b0, 1'b0);
    send(i_instr(6'h23, 16'h8000), 32'h44, 32'h99);
    expect_op("lw", 4'b0010, 32'h44, 32'hFFFF_8000, 2'b00, 1'b0, 1'b0);
    send(r_instr(6'h26), 32'h5, 32'h6);
    expect_op("xor", 4'b0111, 32'h5, 32'h6, 2'b00, 1'b0, 1'b0);
    step();
    check("b2b_drain", 32'(out_valid), 32'd0);

    // Branch set
    send(i_instr(6'h04, 16'h0010), 32'hFFFF_FFFE, 32'd3);
    expect_op("beq", 4'b0110, 32'hFFFF_FFFE, 32'd3, 2'b00, 1'b1, 1'b0);
    send(i_instr(6'h05, 16'h0010), 32'hFFFF_FFFE, 32'd3);
    expect_op("bne", 4'b0110, 32'hFFFF_FFFE, 32'd3, 2'b01, 1'b1, 1'b0);
    send(i_instr(6'h07, 16'h0010), 32'hFFFF_FFFE, 32'd3);
    expect_op("bgtz", 4'b0110, 32'hFFFF_FFFE, 32'd0, 2'b10, 1'b1, 1'b0);
    send(i_instr(6'h06, 16'h0010), 32'hFFFF_FFFE, 32'd3);
    expect_op("blez", 4'b1110, 32'hFFFF_FFFE, 32'd0, 2'b11, 1'b1, 1'b0);
    send(regimm(5'd1), 32'hFFFF_FFFE, 32'd3);
    expect_op("bgez", 4'b0110, 32'hFFFF_FFFE, 32'd0, 2'b11, 1'b1, 1'b0);
    send(regimm(5'd0), 32'hFFFF_FFFE, 32'd3);
    expect_op("bltz", 4'b1110, 32'hFFFF_FFFE, 32'd0, 2'b10, 1'b1, 1'b0);
    step();

    // Stall: second op held off for three cycles
    send(r_instr(6'h20), 32'd1, 32'd2);
    out_ready = 1'b0;
    in_instr  = r_instr(6'h22);
    in_rs_val = 32'd3;
    in_rt_val = 32'd4;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_ready", 32'(in_ready), 32'd0);
      step();
      expect_op("stall_hold", 4'b0010, 32'd1, 32'd2, 2'b00, 1'b0, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    check("unstall_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    expect_op("stall_next", 4'b0110, 32'd3, 32'd4, 2'b00, 1'b0, 1'b0);
    step();
    check("stall_nodup", 32'(out_valid), 32'd0);

    // Flush with a concurrent incoming op
    send(r_instr(6'h24), 32'h9, 32'hA);
    flush     = 1'b1;
    in_instr  = r_instr(6'h25);
    in_rs_val = 32'hB;
    in_rt_val = 32'hC;
    in_valid  = 1'b1;
    #1;
    check("flush_ready", 32'(in_ready), 32'd1);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_vld", 32'(out_valid), 32'd0);
    step();
    check("flush_drop", 32'(out_valid), 32'd0);

    // Reset during a stall
    send(r_instr(6'h26), 32'h55, 32'hAA);
    out_ready = 1'b0;
    step();
    check("rs_stall_vld", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("rs_ready", 32'(in_ready), 32'd0);
    step();
    check("rs_vld", 32'(out_valid), 32'd0);
    check("rs_a",   alu_a, 32'd0);
    check("rs_b",   alu_b, 32'd0);
    check("rs_op",  32'(alu_op), 32'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rs_ready_after", 32'(in_ready), 32'd1);

    // Illegal instructions complete the handshake
    send(i_instr(6'h3F, 16'h1234), 32'h11, 32'h22);
    expect_op("ill_op3f", 4'b0010, 32'h11, 32'h22, 2'b00, 1'b0, 1'b1);
    send(r_instr(6'h00), 32'h33, 32'h44);
    expect_op("ill_fn00", 4'b0010, 32'h33, 32'h44, 2'b00, 1'b0, 1'b1);
    send(regimm(5'd2), 32'h55, 32'h66);
    expect_op("ill_regimm", 4'b0010, 32'h55, 32'h66, 2'b00, 1'b0, 1'b1);
    send(i_instr(6'h09, 16'h0004), 32'h7, 32'h8);
    expect_op("post_ill", 4'b0010, 32'h7, 32'h4, 2'b00, 1'b0, 1'b0);
    step();
    check("final_drain", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX pipeline stage that drives the ALU's input interface: alu_a, alu_b, alu_op and AluzeroCtr.
- Decodes the MIPS opcode/funct fields of an instruction and selects operands: register, sign-extended immediate, zero-extended immediate, or constant zero.
- Registers the result into the EX stage behind a valid/ready handshake with stall and flush.
- Sits between register-file read and the ALU. Branch resolution uses the ALU zero output downstream.

Parameters:
- DATA_W, 32, operand width. The immediate is always 16 bits and is extended to DATA_W.
- ILLEGAL_OP, 4'b0010, alu_op driven for undecodable instructions.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  kill the EX-stage contents and any transfer in this cycle.
- in_valid  in  1  decode stage presents an instruction.
- in_ready  out  1  stage can accept an instruction this cycle.
- in_instr  in  32  instruction word.
- in_rs_val  in  DATA_W  value of register rs.
- in_rt_val  in  DATA_W  value of register rt.
- out_valid  out  1  EX-stage register holds a valid op.
- out_ready  in  1  ALU/EX consumer accepts the op this cycle.
- alu_a  out  DATA_W  ALU operand A, registered.
- alu_b  out  DATA_W  ALU operand B, registered.
- alu_op  out  4  ALU operation, registered.
- AluzeroCtr  out  2  zero-flag mode, registered.
- is_branch  out  1  op is a conditional branch.
- illegal  out  1  instruction not decodable.

Behaviour:
- Reset: when rst=1 at an edge, all outputs clear next cycle: out_valid=0, alu_a=0, alu_b=0, alu_op=0, AluzeroCtr=0, is_branch=0, illegal=0. rst overrides flush and any transfer.
- in_ready is combinational and equals !out_valid || out_ready. It is held 0 while rst=1.
- A transfer occurs when in_valid && in_ready && !flush. On that edge all payload registers load and out_valid becomes 1.
- If out_valid && out_ready and there is no new transfer, out_valid becomes 0. The payload registers hold their values.
- If out_valid && !out_ready (stall), all registers hold. in_valid is ignored in this case.
- flush=1: out_valid becomes 0 on the next edge and any concurrent in_valid is dropped. in_ready stays combinational and is not gated by flush. Payload registers are don't-care.
- Latency: one cycle from accept to out_valid. Throughput is 1 op/cycle when out_ready stays high.
- Field positions: op=[31:26], rs=[25:21], rt=[20:16], funct=[5:0], imm=[15:0]. SE is sign extension, ZE is zero extension.
- R-type (op 0x00):
  - funct 0x20/0x21 give ADD 0010.
  - 0x22/0x23 give SUB 0110.
  - 0x24 gives AND 0000.
  - 0x25 gives OR 0001.
  - 0x26 gives XOR 0111.
  - 0x27 gives NOR 1100.
  - Operands are a=rs, b=rt.
  - Any other funct is illegal.
- I-type arithmetic and memory:
  - 0x08, 0x09, 0x23 (lw) and 0x2B (sw) give ADD with b=SE(imm).
  - 0x0C gives AND with b=ZE(imm).
  - 0x0D gives OR with b=ZE(imm).
  - 0x0E gives XOR with b=ZE(imm).
  - For all of these a=rs.
- Branches set is_branch=1, with a=rs unless stated otherwise:
  - beq 0x04: SUB, b=rt, AluzeroCtr=00.
  - bne 0x05: SUB, b=rt, AluzeroCtr=01.
  - bgtz 0x07: SUB, b=0, AluzeroCtr=10.
  - blez 0x06: FSUB 1110, b=0, AluzeroCtr=11.
  - REGIMM 0x01 with rt=1 (bgez): SUB, b=0, AluzeroCtr=11.
  - REGIMM 0x01 with rt=0 (bltz): FSUB, b=0, AluzeroCtr=10.
  - REGIMM with any other rt is illegal.
- For all non-branch ops, AluzeroCtr=00 and is_branch=0.
- Illegal instructions: illegal=1, alu_op=ILLEGAL_OP, a=rs, b=rt, AluzeroCtr=00, is_branch=0. They still complete the handshake; the stage does not stall on them.
- Reset mid-stall: the op is discarded, and in_ready is 1 in the first cycle after rst deasserts.

Test Plan:
- Reset, then addi $x, imm=0xFFFF with rs=5: out_valid=1 one cycle later; alu_op=0010, alu_a=5, alu_b=0xFFFFFFFF, AluzeroCtr=00.
- ori imm=0x8001 with rs=0x10: alu_op=0001, alu_b=0x00008001. Then R-type funct 0x27 on the next cycle: alu_op=1100. Back-to-back with out_ready=1 gives two consecutive out_valid cycles.
- Branch set with rs=0xFFFFFFFE, rt=3:
  - beq gives 0110/00, b=3.
  - bne gives 0110/01.
  - bgtz gives 0110/10, b=0.
  - blez gives 1110/11, b=0.
  - bgez gives 0110/11.
  - bltz gives 1110/10.
  - is_branch=1 for all six.
- Stall: out_ready=0 for 3 cycles while in_valid=1 with a new instruction. Outputs hold the first op and in_ready=0. When out_ready=1 returns, the second op appears on the next edge and no op is lost or duplicated.
- Flush while out_valid=1 and in_valid=1: out_valid=0 next cycle and the incoming op does not appear. rst asserted during a stall: all outputs are zero next cycle.
- Illegal inputs, op 0x3F and R-type funct 0x00: illegal=1, alu_op=0010, out_valid asserts normally, and the handshake continues.
